// File: rtl/cpu_pkg.sv
// Types and address constants shared by the IF and CP0 stages.
// Redirect encodings are ordered by priority, so a plain compare picks the winner.
package cpu_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    BR   = 2'd1,
    ERET = 2'd2,
    EXC  = 2'd3
  } redirect_t;

  localparam logic [31:0] DEF_RESET_ADDR = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] DEF_ADDR_LO    = 32'h0000_3000;
  localparam logic [31:0] DEF_ADDR_HI    = 32'h0000_6FFC;

  // A newer request of equal rank replaces the older one.
  function automatic logic newer_wins(redirect_t incoming, redirect_t held);
    return incoming >= held;
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Selects the winning redirect from this cycle's inputs and the queued slot.
// Outputs NONE when neither source has a request.
module pc_redirect_arb
  import cpu_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  input  logic [1:0]       pend_type,
  input  logic [WIDTH-1:0] pend_target,
  output logic [1:0]       sel_type,
  output logic [WIDTH-1:0] sel_target,
  output logic             in_any
);

  redirect_t        in_type;
  redirect_t        held_type;
  logic [WIDTH-1:0] in_target;

  assign in_any    = exc_req | eret_req | br_valid;
  assign held_type = redirect_t'(pend_type);

  always_comb begin
    in_type    = NONE;
    in_target  = '0;
    sel_type   = NONE;
    sel_target = '0;
    if (exc_req) begin
      in_type   = EXC;
      in_target = EXC_VECTOR;
    end else if (eret_req) begin
      in_type   = ERET;
      in_target = epc;
    end else if (br_valid) begin
      in_type   = BR;
      in_target = br_target;
    end
    if (newer_wins(in_type, held_type)) begin
      sel_type   = in_type;
      sel_target = in_target;
    end else begin
      sel_type   = held_type;
      sel_target = pend_target;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and IF request generator with a one-deep redirect queue.
//   state | meaning
//   BOOT  | single cycle after reset, no request issued
//   FETCH | normal operation, requests issued from pc
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(DEF_RESET_ADDR),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR),
  parameter int               STEP       = 4,
  parameter logic [WIDTH-1:0] ADDR_LO    = WIDTH'(DEF_ADDR_LO),
  parameter logic [WIDTH-1:0] ADDR_HI    = WIDTH'(DEF_ADDR_HI)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  input  logic             if_ready,
  output logic             if_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             if_adel,
  output logic             redirect_pending
);

  typedef enum logic {BOOT, FETCH} state_t;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  redirect_t        pend_type_q, pend_type_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic             waiting_q;
  logic             locked;
  logic [1:0]       sel_type;
  logic [WIDTH-1:0] sel_target;
  logic             in_any;

  pc_redirect_arb #(
    .WIDTH      (WIDTH),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_arb (
    .br_valid    (br_valid),
    .br_target   (br_target),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .pend_type   (pend_type_q),
    .pend_target (pend_target_q),
    .sel_type    (sel_type),
    .sel_target  (sel_target),
    .in_any      (in_any)
  );

  assign pc               = pc_q;
  assign pc_plus_step     = pc_q + STEP_W;
  assign if_adel          = (pc_q[1:0] != 2'b00) || (pc_q < ADDR_LO) || (pc_q > ADDR_HI);
  // An unaccepted request must stay up even if stall rises afterwards.
  assign if_valid         = (state_q == FETCH) && !if_adel && (!stall || waiting_q);
  assign locked           = if_valid && !if_ready;
  assign redirect_pending = (pend_type_q != NONE);

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_ADDR;
      pend_type_q   <= NONE;
      pend_target_q <= '0;
      waiting_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_type_q   <= pend_type_d;
      pend_target_q <= pend_target_d;
      waiting_q     <= locked;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_type_d   = pend_type_q;
    pend_target_d = pend_target_q;
    if (state_q == BOOT) begin
      state_d = FETCH;
    end
    if (!locked) begin
      if (redirect_t'(sel_type) != NONE) begin
        pc_d          = sel_target;
        pend_type_d   = NONE;
        pend_target_d = '0;
      end else if (if_valid && if_ready) begin
        pc_d = pc_q + STEP_W;
      end
    end else if (in_any) begin
      pend_type_d   = redirect_t'(sel_type);
      pend_target_d = sel_target;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scenarios plus randomized traffic against a cycle-level reference
// model of the fetch unit's documented rules.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_ADDR = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC    = 32'h0000_4180;
  localparam logic [31:0] LO         = 32'h0000_3000;
  localparam logic [31:0] HI         = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = '0;
  logic        if_ready = 1'b0;
  logic        if_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus_step;
  logic        if_adel;
  logic        redirect_pending;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_pc = RESET_ADDR;
  int          m_ppri = 0;
  logic [31:0] m_ptgt = '0;
  logic        m_boot = 1'b1;
  logic        m_wait = 1'b0;
  logic        m_adel;
  logic        m_vld;

  pc_fetch_unit dut (
    .clk              (clk),
    .Reset            (Reset),
    .stall            (stall),
    .br_valid         (br_valid),
    .br_target        (br_target),
    .exc_req          (exc_req),
    .eret_req         (eret_req),
    .epc              (epc),
    .if_ready         (if_ready),
    .if_valid         (if_valid),
    .pc               (pc),
    .pc_plus_step     (pc_plus_step),
    .if_adel          (if_adel),
    .redirect_pending (redirect_pending)
  );

  always #5 clk = ~clk;

  always_comb begin
    m_adel = (m_pc[1:0] != 2'b00) || (m_pc < LO) || (m_pc > HI);
    m_vld  = !m_boot && !m_adel && (!stall || m_wait);
  end

  task automatic model_step();
    int          ip;
    int          wp;
    logic [31:0] it;
    logic [31:0] wt;
    logic        lk;
    ip = 0;
    it = '0;
    if (exc_req) begin
      ip = 3; it = EXC_VEC;
    end else if (eret_req) begin
      ip = 2; it = epc;
    end else if (br_valid) begin
      ip = 1; it = br_target;
    end
    lk = m_vld && !if_ready;
    if (ip >= m_ppri) begin
      wp = ip; wt = it;
    end else begin
      wp = m_ppri; wt = m_ptgt;
    end
    if (Reset) begin
      m_pc = RESET_ADDR; m_ppri = 0; m_ptgt = '0; m_boot = 1'b1; m_wait = 1'b0;
    end else begin
      if (!lk) begin
        if (wp != 0) begin
          m_pc = wt; m_ppri = 0; m_ptgt = '0;
        end else if (m_vld && if_ready) begin
          m_pc = m_pc + 32'd4;
        end
      end else if (ip != 0) begin
        m_ppri = wp; m_ptgt = wt;
      end
      m_wait = lk;
      m_boot = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic test_reset();
    Reset = 1'b1; if_ready = 1'b1; stall = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    #1;
    checks++;
    if (pc !== RESET_ADDR) begin failures++; $display("FAIL reset_pc: got %h expected %h", pc, RESET_ADDR); end
    checks++;
    if (if_valid !== 1'b0) begin failures++; $display("FAIL boot_valid: got %b expected 0", if_valid); end
    checks++;
    if (if_adel !== 1'b0 || redirect_pending !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got adel=%b pend=%b expected 0 0", if_adel, redirect_pending);
    end
    tick();
  endtask

  task automatic test_sequential_and_hold();
    checks++;
    if (if_valid !== 1'b1 || pc !== 32'h3000) begin failures++; $display("FAIL seq0: got v=%b pc=%h expected 1 3000", if_valid, pc); end
    tick();
    checks++;
    if (pc !== 32'h3004) begin failures++; $display("FAIL seq1: got %h expected 3004", pc); end
    for (int i = 0; i < 3; i++) begin
      if_ready = 1'b0; stall = i[0];
      #1;
      checks++;
      if (if_valid !== 1'b1 || pc !== 32'h3004) begin
        failures++; $display("FAIL hold%0d: got v=%b pc=%h expected 1 3004", i, if_valid, pc);
      end
      tick();
    end
    stall = 1'b1; if_ready = 1'b1;
    #1;
    checks++;
    if (if_valid !== 1'b1) begin failures++; $display("FAIL hold_stall: got v=%b expected 1", if_valid); end
    tick();
    stall = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h3008) begin failures++; $display("FAIL seq2: got %h expected 3008", pc); end
  endtask

  task automatic test_pending_branch();
    if_ready = 1'b0; br_valid = 1'b1; br_target = 32'h3400;
    tick();
    br_valid = 1'b0;
    #1;
    checks++;
    if (redirect_pending !== 1'b1 || pc !== 32'h3008) begin
      failures++; $display("FAIL pend_br: got pend=%b pc=%h expected 1 3008", redirect_pending, pc);
    end
    if_ready = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h3400 || redirect_pending !== 1'b0) begin
      failures++; $display("FAIL pend_br_apply: got pc=%h pend=%b expected 3400 0", pc, redirect_pending);
    end
  endtask

  task automatic test_priority();
    br_valid = 1'b1; br_target = 32'h3400; exc_req = 1'b1;
    tick();
    br_valid = 1'b0; exc_req = 1'b0;
    #1;
    checks++;
    if (pc !== EXC_VEC) begin failures++; $display("FAIL prio_same: got %h expected %h", pc, EXC_VEC); end
    tick();
    if_ready = 1'b0; eret_req = 1'b1; epc = 32'h3010;
    tick();
    eret_req = 1'b0; exc_req = 1'b1;
    tick();
    exc_req = 1'b0;
    #1;
    checks++;
    if (redirect_pending !== 1'b1 || pc !== 32'h4184) begin
      failures++; $display("FAIL prio_locked: got pend=%b pc=%h expected 1 4184", redirect_pending, pc);
    end
    if_ready = 1'b1;
    tick();
    checks++;
    if (pc !== EXC_VEC || redirect_pending !== 1'b0) begin
      failures++; $display("FAIL prio_pend_exc: got pc=%h pend=%b expected %h 0", pc, redirect_pending, EXC_VEC);
    end
  endtask

  task automatic test_adel();
    br_valid = 1'b1; br_target = 32'h3002;
    tick();
    br_valid = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h3002 || if_adel !== 1'b1 || if_valid !== 1'b0) begin
      failures++; $display("FAIL adel_mis: got pc=%h adel=%b v=%b expected 3002 1 0", pc, if_adel, if_valid);
    end
    tick(); tick();
    checks++;
    if (pc !== 32'h3002) begin failures++; $display("FAIL adel_hold: got %h expected 3002", pc); end
    exc_req = 1'b1;
    tick();
    exc_req = 1'b0;
    #1;
    checks++;
    if (pc !== EXC_VEC || if_adel !== 1'b0 || if_valid !== 1'b1) begin
      failures++; $display("FAIL adel_exc: got pc=%h adel=%b v=%b expected %h 0 1", pc, if_adel, if_valid, EXC_VEC);
    end
  endtask

  task automatic test_boundaries();
    br_valid = 1'b1; br_target = HI;
    tick();
    br_valid = 1'b0;
    #1;
    checks++;
    if (if_adel !== 1'b0 || if_valid !== 1'b1) begin failures++; $display("FAIL bound_hi: got adel=%b v=%b expected 0 1", if_adel, if_valid); end
    tick();
    checks++;
    if (pc !== 32'h7000 || if_adel !== 1'b1) begin failures++; $display("FAIL bound_past_hi: got pc=%h adel=%b expected 7000 1", pc, if_adel); end
    br_valid = 1'b1; br_target = 32'h2FFC;
    tick();
    br_target = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (if_adel !== 1'b1) begin failures++; $display("FAIL bound_lo: got adel=%b expected 1", if_adel); end
    tick();
    br_valid = 1'b0;
    #1;
    checks++;
    if (pc_plus_step !== 32'h0 || if_adel !== 1'b1) begin
      failures++; $display("FAIL wrap: got step=%h adel=%b expected 0 1", pc_plus_step, if_adel);
    end
    exc_req = 1'b1;
    tick();
    exc_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    if_ready = 1'b0; br_valid = 1'b1; br_target = 32'h3400;
    tick();
    br_valid = 1'b0;
    #1;
    checks++;
    if (redirect_pending !== 1'b1) begin failures++; $display("FAIL mid_pend: got %b expected 1", redirect_pending); end
    Reset = 1'b1;
    tick();
    checks++;
    if (pc !== RESET_ADDR || redirect_pending !== 1'b0 || if_valid !== 1'b0) begin
      failures++; $display("FAIL mid_reset: got pc=%h pend=%b v=%b expected 3000 0 0", pc, redirect_pending, if_valid);
    end
    Reset = 1'b0; if_ready = 1'b1;
    #1;
    checks++;
    if (if_valid !== 1'b0) begin failures++; $display("FAIL mid_boot: got v=%b expected 0", if_valid); end
    tick();
    checks++;
    if (if_valid !== 1'b1 || pc !== RESET_ADDR) begin failures++; $display("FAIL mid_fetch0: got v=%b pc=%h expected 1 3000", if_valid, pc); end
    tick();
    checks++;
    if (pc !== 32'h3004) begin failures++; $display("FAIL mid_fetch1: got %h expected 3004", pc); end
  endtask

  function automatic logic [31:0] rand_target();
    int sel;
    sel = $urandom_range(0, 99);
    if (sel < 75) return LO + (32'($urandom_range(0, 32'hFFF)) << 2);
    else if (sel < 88) return LO + 32'($urandom_range(0, 32'h3FFF));
    else return $urandom;
  endfunction

  task automatic test_random();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      Reset     = ($urandom_range(0, 99) < 2);
      stall     = ($urandom_range(0, 99) < 30);
      if_ready  = ($urandom_range(0, 99) < 60);
      br_valid  = ($urandom_range(0, 99) < 15);
      eret_req  = ($urandom_range(0, 99) < 6);
      exc_req   = ($urandom_range(0, 99) < (m_adel ? 40 : 4));
      br_target = rand_target();
      epc       = rand_target();
      #1;
      checks++;
      if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, pc, m_pc); end
      checks++;
      if (if_valid !== m_vld) begin failures++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, if_valid, m_vld); end
      checks++;
      if (if_adel !== m_adel) begin failures++; $display("FAIL rnd_adel[%0d]: got %b expected %b", i, if_adel, m_adel); end
      checks++;
      if (redirect_pending !== (m_ppri != 0)) begin
        failures++; $display("FAIL rnd_pend[%0d]: got %b expected %b", i, redirect_pending, (m_ppri != 0));
      end
      checks++;
      if (pc_plus_step !== m_pc + 32'd4) begin
        failures++; $display("FAIL rnd_step[%0d]: got %h expected %h", i, pc_plus_step, m_pc + 32'd4);
      end
      tick();
    end
    Reset = 1'b0; br_valid = 1'b0; eret_req = 1'b0; exc_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential_and_hold();
    test_pending_branch();
    test_priority();
    test_adel();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
